// File: rtl/wino_pkg.sv
// ---------------------------------------------------------------------------
// wino_pkg
// Shared definitions for the Winograd datapath control blocks.
//   wfs_state_e          : weight_fetch_scheduler state encoding
//   WINO_OD_W_DEFAULT    : default output-depth counter width
//   WINO_ID_W_DEFAULT    : default input-depth counter width
//   WEIGHT_DRAIN_CYCLES  : depth of the weight controller's od2 pipeline
// ---------------------------------------------------------------------------
package wino_pkg;

    localparam int WINO_OD_W_DEFAULT   = 8;
    localparam int WINO_ID_W_DEFAULT   = 4;
    localparam int WEIGHT_DRAIN_CYCLES = 3;

    typedef enum logic [1:0] {
        WFS_IDLE  = 2'd0,
        WFS_ISSUE = 2'd1,
        WFS_DRAIN = 2'd2
    } wfs_state_e;

endpackage : wino_pkg

// File: rtl/weight_fetch_scheduler.sv
// ---------------------------------------------------------------------------
// weight_fetch_scheduler
// Walks every output-depth pair (od1, od1+1) x input-depth id and issues one
// weight request per unstalled cycle to the weight controller. id is the
// inner loop, the od pair the outer loop. After the last request it waits
// DRAIN_CYCLES cycles (od2 path through the weight controller) and pulses
// done_o.
//
// Ports:
//   clk                 : clock, rising edge
//   reset               : synchronous active-high reset
//   start_i             : start a sweep (honoured only when idle)
//   total_od_i          : number of output depths, latched on accepted start
//   total_id_i          : number of input depths, latched on accepted start
//   stall_i             : PE arrays cannot accept a request this cycle
//   weight_od1_o        : od1 of the current request (always even)
//   weight_id_o         : id of the current request
//   weight_main_valid_o : request issued this cycle
//   od2_masked_o        : with valid, od1+1 is beyond total_od (discard pkg 2)
//   busy_o              : high whenever not idle
//   done_o              : one-cycle pulse at sweep completion
// ---------------------------------------------------------------------------
module weight_fetch_scheduler
    import wino_pkg::*;
#(
    parameter int OD_W         = WINO_OD_W_DEFAULT,
    parameter int ID_W         = WINO_ID_W_DEFAULT,
    parameter int DRAIN_CYCLES = WEIGHT_DRAIN_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [OD_W-1:0] total_od_i,
    input  logic [ID_W-1:0] total_id_i,
    input  logic            stall_i,
    output logic [OD_W-1:0] weight_od1_o,
    output logic [ID_W-1:0] weight_id_o,
    output logic            weight_main_valid_o,
    output logic            od2_masked_o,
    output logic            busy_o,
    output logic            done_o
);

    localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

    wfs_state_e       state_q,  state_d;
    logic [OD_W-1:0]  od1_q,    od1_d;
    logic [ID_W-1:0]  id_q,     id_d;
    logic [OD_W-1:0]  tot_od_q, tot_od_d;
    logic [ID_W-1:0]  tot_id_q, tot_id_d;
    logic [DRN_W-1:0] drain_q,  drain_d;

    // Pair arithmetic is one bit wider so total_od near the top of the range
    // (e.g. 255) terminates at od1=254 instead of wrapping back to 0.
    logic [OD_W:0] od1_p1_s;
    logic [OD_W:0] od1_p2_s;
    logic          id_last_s;
    logic          pair_last_s;
    logic          od2_beyond_s;
    logic          valid_s;
    logic          done_s;

    // Pair / inner-loop boundary detection from registered counters.
    always_comb begin
        od1_p1_s     = {1'b0, od1_q} + (OD_W+1)'(1);
        od1_p2_s     = {1'b0, od1_q} + (OD_W+1)'(2);
        id_last_s    = (id_q == (tot_id_q - ID_W'(1)));
        pair_last_s  = (od1_p2_s >= {1'b0, tot_od_q});
        od2_beyond_s = (od1_p1_s >= {1'b0, tot_od_q});
    end

    // Next-state, counter update and output decode.
    always_comb begin
        state_d  = state_q;
        od1_d    = od1_q;
        id_d     = id_q;
        tot_od_d = tot_od_q;
        tot_id_d = tot_id_q;
        drain_d  = drain_q;
        valid_s  = 1'b0;
        done_s   = 1'b0;

        case (state_q)
            WFS_IDLE: begin
                if (start_i) begin
                    tot_od_d = total_od_i;
                    tot_id_d = total_id_i;
                    od1_d    = '0;
                    id_d     = '0;
                    drain_d  = '0;
                    if ((total_od_i == OD_W'(0)) || (total_id_i == ID_W'(0))) begin
                        state_d = WFS_DRAIN;
                    end else begin
                        state_d = WFS_ISSUE;
                    end
                end else begin
                    state_d = WFS_IDLE;
                end
            end

            WFS_ISSUE: begin
                if (!stall_i) begin
                    valid_s = 1'b1;
                    if (id_last_s) begin
                        id_d  = '0;
                        od1_d = od1_p2_s[OD_W-1:0];
                        if (pair_last_s) begin
                            state_d = WFS_DRAIN;
                            drain_d = '0;
                        end else begin
                            state_d = WFS_ISSUE;
                        end
                    end else begin
                        id_d = id_q + ID_W'(1);
                    end
                end else begin
                    // Stalled: hold every counter, no request.
                    state_d = WFS_ISSUE;
                end
            end

            WFS_DRAIN: begin
                // Drain runs regardless of stall; start is ignored here.
                if (drain_q == DRN_LAST) begin
                    done_s  = 1'b1;
                    drain_d = '0;
                    state_d = WFS_IDLE;
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end

            default: begin
                state_d = WFS_IDLE;
                od1_d   = '0;
                id_d    = '0;
                drain_d = '0;
            end
        endcase
    end

    // State, counter and latched-total registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WFS_IDLE;
            od1_q    <= '0;
            id_q     <= '0;
            tot_od_q <= '0;
            tot_id_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            od1_q    <= od1_d;
            id_q     <= id_d;
            tot_od_q <= tot_od_d;
            tot_id_q <= tot_id_d;
            drain_q  <= drain_d;
        end
    end

    assign weight_od1_o        = od1_q;
    assign weight_id_o         = id_q;
    assign weight_main_valid_o = valid_s;
    assign od2_masked_o        = valid_s & od2_beyond_s;
    assign busy_o              = (state_q != WFS_IDLE);
    assign done_o              = done_s;

endmodule : weight_fetch_scheduler
